logic_unit_pipe: RTL and testbench



---
 rtl/logic_unit_pkg.sv | 18 +
 rtl/logic_unit_comb.sv | 28 ++
 rtl/logic_unit_pipe.sv | 123 ++++++++++++
 tb/tb_logic_unit_pipe.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/logic_unit_pkg.sv
// Shared types and constants for the registered bitwise logic unit.
// LOGIC_UNIT_PIPE_COUNT_EN sizes its optional beat counter from LU_COUNT_W.
package logic_unit_pkg;

  typedef enum logic [2:0] {
    LU_NAND   = 3'd0,
    LU_AND    = 3'd1,
    LU_OR     = 3'd2,
    LU_NOR    = 3'd3,
    LU_XOR    = 3'd4,
    LU_XNOR   = 3'd5,
    LU_NOT_A  = 3'd6,
    LU_PASS_A = 3'd7
  } lu_op_t;

  localparam int unsigned LU_COUNT_W = 16;

endpackage

// File: rtl/logic_unit_comb.sv
// Purely combinational bitwise function f(A, B, op) of parametrised width.
module logic_unit_comb
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  lu_op_t           op_i,
  output logic [WIDTH-1:0] y_o
);

  always_comb begin
    y_o = '0;
    unique case (op_i)
      LU_NAND:   y_o = ~(a_i & b_i);
      LU_AND:    y_o = a_i & b_i;
      LU_OR:     y_o = a_i | b_i;
      LU_NOR:    y_o = ~(a_i | b_i);
      LU_XOR:    y_o = a_i ^ b_i;
      LU_XNOR:   y_o = ~(a_i ^ b_i);
      LU_NOT_A:  y_o = ~a_i;
      LU_PASS_A: y_o = a_i;
      default:   y_o = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered bitwise logic unit with accumulator operand and valid/ready on both sides.
// Defining LOGIC_UNIT_PIPE_COUNT_EN adds a saturating beat_count output.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      inA,
  input  logic [WIDTH-1:0]      inB,
  input  logic [2:0]            op,
  input  logic                  acc_sel,
  input  logic                  acc_clr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      outY,
  output logic                  zero,
  output logic                  ones
`ifdef LOGIC_UNIT_PIPE_COUNT_EN
  ,
  output logic [LU_COUNT_W-1:0] beat_count
`endif
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             valid_q, valid_d;
  logic             zero_q, zero_d;
  logic             ones_q, ones_d;
  logic [WIDTH-1:0] a_eff;
  logic [WIDTH-1:0] res;
  logic             in_fire;
  logic             out_fire;

  assign in_ready = !valid_q | out_ready;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = valid_q & out_ready;

  // The accumulator updates at accept time, so chained beats see it before downstream consumes.
  always_comb begin
    a_eff = inA;
    if (acc_clr) begin
      a_eff = '0;
    end else if (acc_sel) begin
      a_eff = acc_q;
    end
  end

  logic_unit_comb #(
    .WIDTH(WIDTH)
  ) u_comb (
    .a_i (a_eff),
    .b_i (inB),
    .op_i(lu_op_t'(op)),
    .y_o (res)
  );

  always_comb begin
    acc_d   = acc_q;
    y_d     = y_q;
    valid_d = valid_q;
    zero_d  = zero_q;
    ones_d  = ones_q;
    if (in_fire) begin
      acc_d   = res;
      y_d     = res;
      valid_d = 1'b1;
      zero_d  = (res == '0);
      ones_d  = (res == '1);
    end else if (out_fire) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q   <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      zero_q  <= 1'b1;
      ones_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      zero_q  <= zero_d;
      ones_q  <= ones_d;
    end
  end

  assign out_valid = valid_q;
  assign outY      = y_q;
  assign zero      = zero_q;
  assign ones      = ones_q;

`ifdef LOGIC_UNIT_PIPE_COUNT_EN
  logic [LU_COUNT_W-1:0] cnt_q, cnt_d;

  // Clear beats take priority over a coincident out_fire increment.
  always_comb begin
    cnt_d = cnt_q;
    if (in_fire && acc_clr) begin
      cnt_d = '0;
    end else if (out_fire && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign beat_count = cnt_q;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed self-checking bench for logic_unit_pipe (WIDTH=8).
// Counter checks are compiled in when LOGIC_UNIT_PIPE_COUNT_EN is defined.
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] inA;
  logic [7:0] inB;
  logic [2:0] op;
  logic       acc_sel;
  logic       acc_clr;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] outY;
  logic       zero;
  logic       ones;
`ifdef LOGIC_UNIT_PIPE_COUNT_EN
  logic [15:0] beat_count;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  logic_unit_pipe #(
    .WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .inA      (inA),
    .inB      (inB),
    .op       (op),
    .acc_sel  (acc_sel),
    .acc_clr  (acc_clr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .outY     (outY),
    .zero     (zero),
    .ones     (ones)
`ifdef LOGIC_UNIT_PIPE_COUNT_EN
    ,
    .beat_count(beat_count)
`endif
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [7:0] a,
                       input logic [7:0] b, input logic s, input logic c);
    in_valid = v;
    op       = o;
    inA      = a;
    inB      = b;
    acc_sel  = s;
    acc_clr  = c;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] y,
                           input logic z, input logic o);
    check({tag, ".valid"}, 16'(out_valid), 16'(v));
    check({tag, ".outY"},  16'(outY),      16'(y));
    check({tag, ".zero"},  16'(zero),      16'(z));
    check({tag, ".ones"},  16'(ones),      16'(o));
  endtask

  logic [7:0] sweep_exp [8];

  initial begin
    sweep_exp[0] = 8'hFA; sweep_exp[1] = 8'h05; sweep_exp[2] = 8'hAF; sweep_exp[3] = 8'h50;
    sweep_exp[4] = 8'hAA; sweep_exp[5] = 8'h55; sweep_exp[6] = 8'h5A; sweep_exp[7] = 8'hA5;

    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    tick(); tick();
    check_out("reset", 1'b0, 8'h00, 1'b1, 1'b0);
    check("reset.in_ready", 16'(in_ready), 16'd1);
    rst = 1'b0;
    tick();

    // NAND F0,CC -> 3F
    drive(1'b1, 3'd0, 8'hF0, 8'hCC, 1'b0, 1'b0);
    tick();
    check_out("nand", 1'b1, 8'h3F, 1'b0, 1'b0);

    // Back-to-back op sweep
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 3'(i), 8'hA5, 8'h0F, 1'b0, 1'b0);
      tick();
      check_out($sformatf("sweep%0d", i), 1'b1, sweep_exp[i], 1'b0, 1'b0);
    end
    drive(1'b1, 3'd1, 8'hA5, 8'h00, 1'b0, 1'b0);
    tick();
    check_out("and_zero", 1'b1, 8'h00, 1'b1, 1'b0);
    drive(1'b1, 3'd2, 8'hF0, 8'h0F, 1'b0, 1'b0);
    tick();
    check_out("or_ones", 1'b1, 8'hFF, 1'b0, 1'b1);

    // Backpressure
    drive(1'b1, 3'd0, 8'hF0, 8'hCC, 1'b0, 1'b0);
    tick();
    check_out("bp_load", 1'b1, 8'h3F, 1'b0, 1'b0);
    out_ready = 1'b0;
    drive(1'b1, 3'd7, 8'h00, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("bp_in_ready%0d", i), 16'(in_ready), 16'd0);
      tick();
      check_out($sformatf("bp_hold%0d", i), 1'b1, 8'h3F, 1'b0, 1'b0);
    end
    out_ready = 1'b1;
    drive(1'b1, 3'd1, 8'hFF, 8'h5A, 1'b0, 1'b0);
    #1;
    check("bp_release_ready", 16'(in_ready), 16'd1);
    tick();
    check_out("bp_next", 1'b1, 8'h5A, 1'b0, 1'b0);
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    check_out("drain", 1'b0, 8'h5A, 1'b0, 1'b0);

    // Accumulate chain
    drive(1'b1, 3'd2, 8'h77, 8'h01, 1'b1, 1'b1);
    tick();
    check_out("acc1", 1'b1, 8'h01, 1'b0, 1'b0);
    drive(1'b1, 3'd4, 8'h77, 8'h03, 1'b1, 1'b0);
    tick();
    check_out("acc2", 1'b1, 8'h02, 1'b0, 1'b0);
    tick();
    check_out("acc3", 1'b1, 8'h01, 1'b0, 1'b0);
    drive(1'b1, 3'd3, 8'h77, 8'h00, 1'b1, 1'b0);
    tick();
    check_out("acc4", 1'b1, 8'hFE, 1'b0, 1'b0);
    out_ready = 1'b0;
    drive(1'b1, 3'd7, 8'h33, 8'h00, 1'b1, 1'b0);
    tick();
    check_out("acc_stall", 1'b1, 8'hFE, 1'b0, 1'b0);
    out_ready = 1'b1;
    tick();
    check_out("acc_pass", 1'b1, 8'hFE, 1'b0, 1'b0);
    drive(1'b1, 3'd6, 8'h33, 8'h00, 1'b1, 1'b0);
    tick();
    check_out("acc_not", 1'b1, 8'h01, 1'b0, 1'b0);

    // Async reset mid-stall, checked before the next clock edge
    out_ready = 1'b0;
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    check_out("pre_rst", 1'b1, 8'h01, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    check_out("async_rst", 1'b0, 8'h00, 1'b1, 1'b0);
    #1 rst = 1'b0;
    #1;
    check("rst_in_ready", 16'(in_ready), 16'd1);
    out_ready = 1'b1;
    drive(1'b1, 3'd7, 8'h99, 8'h00, 1'b1, 1'b0);
    tick();
    check_out("acc_after_rst", 1'b1, 8'h00, 1'b1, 1'b0);
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    tick();

`ifdef LOGIC_UNIT_PIPE_COUNT_EN
    rst = 1'b1;
    tick();
    check("cnt_reset", beat_count, 16'd0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 3'd7, 8'(i), 8'h00, 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    check("cnt_ten", beat_count, 16'd10);
    drive(1'b1, 3'd2, 8'h00, 8'h01, 1'b0, 1'b1);
    tick();
    check("cnt_clr", beat_count, 16'd0);
    drive(1'b1, 3'd7, 8'h11, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 65540; i++) tick();
    check("cnt_sat", beat_count, 16'hFFFF);
    tick();
    check("cnt_sat_hold", beat_count, 16'hFFFF);
    drive(1'b1, 3'd2, 8'h00, 8'h01, 1'b0, 1'b1);
    tick();
    check("cnt_clr_wins", beat_count, 16'd0);
    drive(1'b0, 3'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    check("cnt_after_clr", beat_count, 16'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
